// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, IR handshake, redirect/flush
// controls and pre-split decode fields.
interface fetch_stage_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] imem_pc;
  logic [31:0]     imem_instr;
  logic [31:0]     ir;
  logic [PC_W-1:0] ir_pc;
  logic            ir_valid;
  logic            ir_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic [PC_W-1:0] flush_pc;
  logic [5:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [15:0]     imm;
  logic            is_nop;
  logic [31:0]     fetch_count;

  // Fetch stage side
  modport master (
    output imem_pc,
    input  imem_instr,
    output ir,
    output ir_pc,
    output ir_valid,
    input  ir_ready,
    input  redirect_valid,
    input  redirect_pc,
    input  flush,
    input  flush_pc,
    output opcode,
    output rd,
    output rs,
    output rt,
    output imm,
    output is_nop,
    output fetch_count
  );

  // Memory / downstream side
  modport slave (
    input  imem_pc,
    output imem_instr,
    input  ir,
    input  ir_pc,
    input  ir_valid,
    output ir_ready,
    output redirect_valid,
    output redirect_pc,
    output flush,
    output flush_pc,
    input  opcode,
    input  rd,
    input  rs,
    input  rt,
    input  imm,
    input  is_nop,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, reads a combinational IMem, latches
// the word into the IR and offers it downstream over a valid/ready handshake.
module fetch_stage #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned PC_STEP   = 1,
  parameter int unsigned IMEM_WAIT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] ir_pc_q, ir_pc_d;
  logic            ir_valid_q, ir_valid_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            accept;
  logic            capture;

  // en gates the accept so a frozen stage never consumes a handshake
  assign accept = ir_valid_q & bus.ir_ready & en_i;

  // Next-state: flush beats everything, then en gates the FSM
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    wait_cnt_d    = wait_cnt_q;
    fetch_count_d = fetch_count_q;
    capture       = 1'b0;

    if (bus.flush) begin
      pc_d       = bus.flush_pc;
      ir_valid_d = 1'b0;
      wait_cnt_d = 4'd0;
      state_d    = StFetch;
    end else if (en_i) begin
      unique case (state_q)
        StFetch: begin
          if (IMEM_WAIT == 0) begin
            capture = 1'b1;
          end else begin
            wait_cnt_d = 4'd1;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == 4'(IMEM_WAIT)) begin
            capture    = 1'b1;
            wait_cnt_d = 4'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        StHold: begin
          // Redirect only matters when the word is actually consumed
          if (accept) begin
            pc_d       = bus.redirect_valid ? bus.redirect_pc : pc_q + PC_W'(PC_STEP);
            ir_valid_d = 1'b0;
            state_d    = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase

      if (capture) begin
        ir_d       = bus.imem_instr;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b1;
        state_d    = StHold;
        if (fetch_count_q != 32'hFFFF_FFFF) begin
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StFetch;
      pc_q          <= '0;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      wait_cnt_q    <= 4'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_pc     = pc_q;
  assign bus.ir          = ir_q;
  assign bus.ir_pc       = ir_pc_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.fetch_count = fetch_count_q;

  // Decode fields straight from the IR; rt and imm overlap by design
  assign bus.opcode = ir_q[31:26];
  assign bus.rd     = ir_q[25:21];
  assign bus.rs     = ir_q[20:16];
  assign bus.rt     = ir_q[15:11];
  assign bus.imm    = ir_q[15:0];
  assign bus.is_nop = (ir_q == 32'h0);

endmodule
